// File: rtl/ttl_decoder_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ttl_decoder_seq_if
//  Description : Bundles the decode, latch and scan controls and the
//                registered decoder outputs of ttl_decoder_seq.
//                master : address/enable/scan source (CPU, video logic, bench)
//                slave  : the decoder itself
//  Signals     : Enable1_bar, Enable2_bar, Enable3 - 74138-style enables
//                LatchEn_bar  - 0 = address transparent, 1 = hold latch
//                A            - decode address (WIDTH_IN bits)
//                Mode         - 0 = decode, 1 = scan
//                Scan_start   - request one scan frame
//                Y            - active-low outputs (WIDTH_OUT bits)
//                Slot         - current scan slot index
//                Scan_busy    - frame in progress
//                Scan_done    - one-cycle end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface ttl_decoder_seq_if #(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
);
  logic                 Enable1_bar;
  logic                 Enable2_bar;
  logic                 Enable3;
  logic                 LatchEn_bar;
  logic [WIDTH_IN-1:0]  A;
  logic                 Mode;
  logic                 Scan_start;
  logic [WIDTH_OUT-1:0] Y;
  logic [WIDTH_IN-1:0]  Slot;
  logic                 Scan_busy;
  logic                 Scan_done;

  modport master (
    output Enable1_bar, Enable2_bar, Enable3, LatchEn_bar, A, Mode, Scan_start,
    input  Y, Slot, Scan_busy, Scan_done
  );

  modport slave (
    input  Enable1_bar, Enable2_bar, Enable3, LatchEn_bar, A, Mode, Scan_start,
    output Y, Slot, Scan_busy, Scan_done
  );
endinterface
`default_nettype wire

// File: rtl/ttl_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ttl_decoder_seq
//  Description : Clocked 74138/74137-style active-low line decoder with an
//                address latch, registered (glitch-free) outputs and a scan
//                sequencer that walks the active-low select across every
//                output with a DWELL-cycle low time and a one-cycle
//                break-before-make gap between slots.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - ttl_decoder_seq_if.slave (enables, latch control,
//                         address, mode, scan start, Y, Slot, Scan_busy,
//                         Scan_done)
//  Parameters  : WIDTH_OUT - number of outputs (any value >= 2)
//                WIDTH_IN  - address width
//                DWELL     - low cycles per slot in scan mode (1..255)
//  Options     : TTL_DECODER_SEQ_CONTINUOUS_EN - when defined the scanner
//                wraps from the last slot back to slot 0 instead of
//                returning to IDLE; Scan_done still pulses once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttl_decoder_seq #(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT),
  parameter int DWELL     = 4
) (
  input wire clk,
  input wire rst_n,
  ttl_decoder_seq_if.slave bus
);

  localparam logic [7:0]          c_DWELL     = 8'(DWELL);
  localparam logic [WIDTH_IN-1:0] c_LAST_SLOT = WIDTH_IN'(WIDTH_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH_IN-1:0]  r_aq;
  logic [WIDTH_IN-1:0]  r_slot;
  logic [WIDTH_IN-1:0]  w_slot_nxt;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_nxt;
  logic                 r_low;
  logic                 w_low_nxt;
  logic [WIDTH_OUT-1:0] r_y;
  logic [WIDTH_OUT-1:0] w_y_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_done_nxt;

  logic                 w_en;
  logic [WIDTH_IN-1:0]  w_addr;
  logic [WIDTH_IN-1:0]  w_slot_inc;
  logic [7:0]           w_cnt_inc;
  logic                 w_slot_last;

  // Active-low one-cold decode; indices past WIDTH_OUT-1 leave every bit high.
  function automatic logic [WIDTH_OUT-1:0] f_decode(
    input logic [WIDTH_IN-1:0] idx,
    input logic                en
  );
    logic [WIDTH_OUT-1:0] v;
    v = '1;
    for (int i = 0; i < WIDTH_OUT; i++) begin
      if (en && (idx == WIDTH_IN'(i))) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign w_en        = !bus.Enable1_bar && !bus.Enable2_bar && bus.Enable3;
  // 74137 behaviour: transparent while LatchEn_bar is low.
  assign w_addr      = bus.LatchEn_bar ? r_aq : bus.A;
  assign w_slot_inc  = r_slot + WIDTH_IN'(1);
  assign w_slot_last = (r_slot == c_LAST_SLOT);
  // r_low marks that the cycle now ending actually drove a line low, so only
  // enabled cycles count towards the dwell; disabled cycles freeze the count.
  assign w_cnt_inc   = r_cnt + {7'd0, r_low};

  // --------------------------------------------------------------------------
  // Address latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aq <= '0;
    end else if (!bus.LatchEn_bar) begin
      r_aq <= bus.A;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_low   <= 1'b0;
      r_y     <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_cnt   <= w_cnt_nxt;
      r_low   <= w_low_nxt;
      r_y     <= w_y_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Y is computed for the cycle that
  // follows the edge, which is what keeps the outputs registered and gives
  // Y[0] low in the very first cycle after the Scan_start edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_cnt_nxt   = r_cnt;
    w_low_nxt   = 1'b0;
    w_y_nxt     = '1;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!bus.Mode) begin
          w_y_nxt = f_decode(w_addr, w_en);
        end else if (bus.Scan_start) begin
          w_state_nxt = S_DRIVE;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
          w_y_nxt     = f_decode('0, w_en);
          w_low_nxt   = w_en;
        end
      end

      S_DRIVE: begin
        if (!bus.Mode) begin
          // Abort: outputs released, no end-of-frame pulse.
          w_state_nxt = S_IDLE;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == c_DWELL) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = w_cnt_inc;
          // The pulse lands on the last slot's gap cycle.
          w_done_nxt  = w_slot_last;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_y_nxt     = f_decode(r_slot, w_en);
          w_low_nxt   = w_en;
        end
      end

      S_GAP: begin
        if (!bus.Mode) begin
          w_state_nxt = S_IDLE;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (!w_slot_last) begin
          w_state_nxt = S_DRIVE;
          w_slot_nxt  = w_slot_inc;
          w_cnt_nxt   = '0;
          w_y_nxt     = f_decode(w_slot_inc, w_en);
          w_low_nxt   = w_en;
        end else begin
`ifdef TTL_DECODER_SEQ_CONTINUOUS_EN
          // Wrap to slot 0 without passing through IDLE so Scan_busy holds.
          w_state_nxt = S_DRIVE;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
          w_y_nxt     = f_decode('0, w_en);
          w_low_nxt   = w_en;
`else
          w_state_nxt = S_IDLE;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
`endif
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_slot_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.Y         = r_y;
  assign bus.Slot      = r_slot;
  assign bus.Scan_busy = r_busy;
  assign bus.Scan_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ttl_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ttl_decoder_seq
//  Description : Self-checking bench for ttl_decoder_seq. An 8-output and a
//                6-output instance are exercised in decode, latch, scan,
//                enable-pause, abort and reset scenarios against reference
//                models built from the decoder's rules (address arithmetic
//                and a queue of per-frame low/gap slots).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ttl_decoder_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    int slot;
    bit gap;
    bit last;
  } item_t;

  ttl_decoder_seq_if #(.WIDTH_OUT(8)) bus8 ();
  ttl_decoder_seq_if #(.WIDTH_OUT(6)) bus6 ();

  ttl_decoder_seq #(.WIDTH_OUT(8), .DWELL(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  ttl_decoder_seq #(.WIDTH_OUT(6), .DWELL(4)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp8(input int addr, input bit en);
    logic [7:0] v;
    v = 8'hFF;
    if (en && addr >= 0 && addr < 8) v[addr] = 1'b0;
    return v;
  endfunction

  function automatic bit pick_en(input int mode, input int c);
    if (mode == 1) return !(c >= 12 && c <= 14);
    if (mode == 2) return ($urandom_range(0, 4) != 0);
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8: Y=%h Slot=%0d busy=%b done=%b, expected FF/0/0/0",
               bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done);
    end
    checks++;
    if ({bus6.Y, bus6.Slot, bus6.Scan_busy, bus6.Scan_done} !== {6'h3F, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset6: Y=%h Slot=%0d busy=%b done=%b, expected 3F/0/0/0",
               bus6.Y, bus6.Slot, bus6.Scan_busy, bus6.Scan_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [2:0] aq_m;
    logic [2:0] a;
    bit lb;
    bit en;
    logic [7:0] ey;
    bus8.Mode = 1'b0;
    bus8.LatchEn_bar = 1'b0;
    bus8.Enable1_bar = 1'b0;
    bus8.Enable2_bar = 1'b0;
    bus8.Enable3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus8.A = 3'(i);
      @(posedge clk); #1;
      checks++;
      if (bus8.Y !== exp8(i, 1'b1)) begin
        errors++;
        $display("FAIL decode_sweep a=%0d: Y=%h expected %h", i, bus8.Y, exp8(i, 1'b1));
      end
    end
    @(negedge clk);
    bus8.Enable3 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.Y !== 8'hFF) begin
      errors++;
      $display("FAIL decode_g1_off: Y=%h expected FF", bus8.Y);
    end
    // Random decode traffic, latch and enables included; Scan_start with
    // Mode=0 must be ignored.
    aq_m = 3'd7;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      a  = 3'($urandom_range(0, 7));
      lb = 1'($urandom_range(0, 1));
      bus8.A = a;
      bus8.LatchEn_bar = lb;
      bus8.Enable1_bar = ($urandom_range(0, 3) == 0);
      bus8.Enable2_bar = ($urandom_range(0, 3) == 0);
      bus8.Enable3     = ($urandom_range(0, 3) != 0);
      bus8.Scan_start  = 1'($urandom_range(0, 1));
      en = !bus8.Enable1_bar && !bus8.Enable2_bar && bus8.Enable3;
      ey = exp8(lb ? int'(aq_m) : int'(a), en);
      if (!lb) aq_m = a;
      @(posedge clk); #1;
      checks++;
      if (bus8.Y !== ey || bus8.Scan_busy !== 1'b0) begin
        errors++;
        $display("FAIL decode_rand %0d: Y=%h busy=%b expected %h/0", i, bus8.Y, bus8.Scan_busy, ey);
      end
    end
    bus8.Scan_start = 1'b0;
    bus8.Enable1_bar = 1'b0;
    bus8.Enable2_bar = 1'b0;
    bus8.Enable3 = 1'b1;
  endtask

  task automatic test_latch();
    @(negedge clk);
    bus8.Mode = 1'b0;
    bus8.A = 3'd3;
    bus8.LatchEn_bar = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.Y !== 8'hF7) begin
      errors++;
      $display("FAIL latch_load: Y=%h expected F7", bus8.Y);
    end
    @(negedge clk);
    bus8.LatchEn_bar = 1'b1;
    bus8.A = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus8.Y !== 8'hF7) begin
        errors++;
        $display("FAIL latch_hold %0d: Y=%h expected F7", i, bus8.Y);
      end
    end
    @(negedge clk);
    bus8.LatchEn_bar = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.Y !== 8'hBF) begin
      errors++;
      $display("FAIL latch_release: Y=%h expected BF", bus8.Y);
    end
  endtask

  // en_mode: 0 = always enabled, 1 = 3-cycle pause in slot 2, 2 = random
  // enables plus random (ignored) Scan_start while busy.
  task automatic test_scan_frame(input int en_mode, input int exp_len, input string name);
    item_t q[$];
    item_t it;
    int c;
    int done_c;
    bit en_c;
    bit finished;
    logic [7:0] ey;
    int es;
    bit ed;
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 4; d++) q.push_back('{slot: s, gap: 1'b0, last: 1'b0});
      q.push_back('{slot: s, gap: 1'b1, last: (s == 7)});
    end
    @(negedge clk);
    bus8.Mode = 1'b1;
    bus8.Scan_start = 1'b1;
    en_c = pick_en(en_mode, 1);
    bus8.Enable1_bar = !en_c;
    c = 1;
    done_c = 0;
    finished = 1'b0;
    while (!finished && c <= 200) begin
      if (c > 1) begin
        @(negedge clk);
        bus8.Scan_start = (en_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        en_c = pick_en(en_mode, c);
        bus8.Enable1_bar = !en_c;
      end
      @(posedge clk); #1;
      it = q[0];
      ed = 1'b0;
      es = it.slot;
      if (!it.gap && !en_c) begin
        ey = 8'hFF;
      end else begin
        void'(q.pop_front());
        ey = it.gap ? 8'hFF : exp8(it.slot, 1'b1);
        ed = it.last;
      end
      checks++;
      if ({bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done} !== {ey, 3'(es), 1'b1, ed}) begin
        errors++;
        $display("FAIL %s cycle %0d: Y=%h Slot=%0d busy=%b done=%b expected %h/%0d/1/%b",
                 name, c, bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done, ey, es, ed);
      end
      checks++;
      if ($countones(~bus8.Y) > 1) begin
        errors++;
        $display("FAIL %s bbm cycle %0d: Y=%h has more than one low bit", name, c, bus8.Y);
      end
      if (ed) begin
        finished = 1'b1;
        done_c = c;
      end
      c++;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: no Scan_done within 200 cycles, expected one", name);
    end else if (exp_len > 0 && done_c != exp_len) begin
      errors++;
      $display("FAIL %s length: done at cycle %0d expected %0d", name, done_c, exp_len);
    end
    @(negedge clk);
    bus8.Scan_start = 1'b0;
    bus8.Enable1_bar = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus8.Y, bus8.Scan_busy, bus8.Scan_done} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s post: Y=%h busy=%b done=%b expected FF/0/0",
               name, bus8.Y, bus8.Scan_busy, bus8.Scan_done);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    bus8.Mode = 1'b1;
    bus8.Scan_start = 1'b1;
    bus8.Enable1_bar = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      if (c > 1) begin
        @(negedge clk);
        bus8.Scan_start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus8.Scan_done) saw_done = 1'b1;
    end
    checks++;
    if (bus8.Slot !== 3'd5 || bus8.Y !== 8'hDF) begin
      errors++;
      $display("FAIL abort_pre: Slot=%0d Y=%h expected 5/DF", bus8.Slot, bus8.Y);
    end
    @(negedge clk);
    bus8.Mode = 1'b0;
    bus8.A = 3'd0;
    bus8.LatchEn_bar = 1'b0;
    @(posedge clk); #1;
    if (bus8.Scan_done) saw_done = 1'b1;
    checks++;
    if ({bus8.Y, bus8.Slot, bus8.Scan_busy, saw_done} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort: Y=%h Slot=%0d busy=%b sawdone=%b expected FF/0/0/0",
               bus8.Y, bus8.Slot, bus8.Scan_busy, saw_done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.Y !== 8'hFE || bus8.Scan_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_decode: Y=%h done=%b expected FE/0", bus8.Y, bus8.Scan_done);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    bus8.A = 3'd5;
    bus8.LatchEn_bar = 1'b0;
    bus8.Mode = 1'b1;
    bus8.Scan_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) begin
        @(negedge clk);
        bus8.Scan_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus8.Y !== 8'hFB || bus8.Scan_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: Y=%h busy=%b expected FB/1", bus8.Y, bus8.Scan_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: Y=%h Slot=%0d busy=%b done=%b expected FF/0/0/0",
               bus8.Y, bus8.Slot, bus8.Scan_busy, bus8.Scan_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus8.Mode = 1'b0;
    bus8.LatchEn_bar = 1'b1;
    bus8.A = 3'd6;
    @(posedge clk); #1;
    checks++;
    if (bus8.Y !== 8'hFE || bus8.Scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_latch: Y=%h busy=%b expected FE/0", bus8.Y, bus8.Scan_busy);
    end
    @(negedge clk);
    bus8.LatchEn_bar = 1'b0;
  endtask

  task automatic test_width6();
    int ncyc;
    int p;
    int sl;
    logic [5:0] ey;
    bit ed;
    @(negedge clk);
    bus6.Mode = 1'b0;
    bus6.Enable1_bar = 1'b0;
    bus6.Enable2_bar = 1'b0;
    bus6.Enable3 = 1'b1;
    bus6.LatchEn_bar = 1'b0;
    bus6.A = 3'd7;
    @(posedge clk); #1;
    checks++;
    if (bus6.Y !== 6'h3F) begin
      errors++;
      $display("FAIL w6_addr7: Y=%h expected 3F", bus6.Y);
    end
    @(negedge clk);
    bus6.A = 3'd5;
    @(posedge clk); #1;
    checks++;
    if (bus6.Y !== 6'h1F) begin
      errors++;
      $display("FAIL w6_addr5: Y=%h expected 1F", bus6.Y);
    end
`ifdef TTL_DECODER_SEQ_CONTINUOUS_EN
    ncyc = 65;
`else
    ncyc = 30;
`endif
    @(negedge clk);
    bus6.Mode = 1'b1;
    bus6.Scan_start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin
        @(negedge clk);
        bus6.Scan_start = 1'b0;
      end
      @(posedge clk); #1;
      p  = (c - 1) % 30;
      sl = p / 5;
      ey = 6'h3F;
      if (p % 5 < 4) ey[sl] = 1'b0;
      ed = (p == 29);
      checks++;
      if ({bus6.Y, bus6.Slot, bus6.Scan_busy, bus6.Scan_done} !== {ey, 3'(sl), 1'b1, ed}) begin
        errors++;
        $display("FAIL w6_scan cycle %0d: Y=%h Slot=%0d busy=%b done=%b expected %h/%0d/1/%b",
                 c, bus6.Y, bus6.Slot, bus6.Scan_busy, bus6.Scan_done, ey, sl, ed);
      end
    end
`ifdef TTL_DECODER_SEQ_CONTINUOUS_EN
    @(negedge clk);
    bus6.Mode = 1'b0;
    bus6.Enable3 = 1'b0;
`endif
    @(posedge clk); #1;
    checks++;
    if ({bus6.Y, bus6.Scan_busy, bus6.Scan_done} !== {6'h3F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL w6_end: Y=%h busy=%b done=%b expected 3F/0/0",
               bus6.Y, bus6.Scan_busy, bus6.Scan_done);
    end
    @(negedge clk);
    bus6.Mode = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus8.Enable1_bar = 1'b0;
    bus8.Enable2_bar = 1'b0;
    bus8.Enable3     = 1'b1;
    bus8.LatchEn_bar = 1'b0;
    bus8.A           = '0;
    bus8.Mode        = 1'b0;
    bus8.Scan_start  = 1'b0;
    bus6.Enable1_bar = 1'b1;
    bus6.Enable2_bar = 1'b0;
    bus6.Enable3     = 1'b1;
    bus6.LatchEn_bar = 1'b0;
    bus6.A           = '0;
    bus6.Mode        = 1'b0;
    bus6.Scan_start  = 1'b0;

    test_reset();
    test_decode();
    test_latch();
    test_scan_frame(0, 40, "single_frame");
    test_scan_frame(1, 43, "en_pause");
    test_scan_frame(2, 0, "rand_frame_a");
    test_scan_frame(2, 0, "rand_frame_b");
    test_abort();
    test_reset_midframe();
    test_width6();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ttl_decoder_seq.md
# ttl_decoder_seq

Parametrised, clocked successor to the 74138-style active-low line decoder. It adds a 74137-style address latch, registered glitch-free outputs, and a built-in scan sequencer that walks the active-low select through every output with programmable dwell and break-before-make gaps. It sits between CPU or video address logic and chip-select, strobe or keyboard/DIP-matrix scan lines wherever a plain combinational decoder would glitch or would need an external counter.

## Interface
Parameters:
- WIDTH_OUT, 8, number of active-low outputs; need not be a power of two.
- WIDTH_IN, $clog2(WIDTH_OUT), address width.
- DWELL, 4, cycles each output is held low in scan mode; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Enable1_bar  in  1  active-low enable (G2A).
- Enable2_bar  in  1  active-low enable (G2B).
- Enable3  in  1  active-high enable (G1).
- LatchEn_bar  in  1  0 = address transparent, 1 = hold latched address.
- A  in  WIDTH_IN  decode address.
- Mode  in  1  0 = decode mode, 1 = scan mode.
- Scan_start  in  1  starts a scan frame; sampled in IDLE only.
- Y  out  WIDTH_OUT  registered active-low outputs.
- Slot  out  WIDTH_IN  current scan slot index.
- Scan_busy  out  1  high while a frame is in progress.
- Scan_done  out  1  one-cycle end-of-frame pulse.

## Operation
- en = !Enable1_bar & !Enable2_bar & Enable3.
- Address latch a_q: loads A on every edge while LatchEn_bar=0 and holds while LatchEn_bar=1. Effective address is A when LatchEn_bar=0, a_q otherwise.
- Decode mode (Mode=0, FSM in IDLE): Y[i]=0 only for i == effective address with en=1. All other bits are 1.
  - Address >= WIDTH_OUT gives all ones.
  - en=0 gives all ones.
- Scan FSM states: IDLE, DRIVE, GAP.
  - IDLE, with Mode=1 and Scan_start=1: Slot<=0, dwell counter<=0, go to DRIVE.
  - DRIVE: Y[Slot]=0 (gated by en). Dwell counter increments. After DWELL counted cycles, go to GAP.
  - GAP: one cycle with Y all ones.
    - If Slot < WIDTH_OUT-1: Slot+1, back to DRIVE.
    - Otherwise: Scan_done=1 for this cycle, then go to IDLE.
- en=0 during DRIVE: Y all ones and the dwell counter freezes; the slot resumes when en returns. GAP cycles are not frozen.
- Mode=0 while busy: abort to IDLE on the next edge. Y all ones that cycle, no Scan_done pulse, Slot<=0.
- Scan_start while busy: ignored. Scan_start with Mode=0: ignored.
- In IDLE with Mode=1, Y is all ones.

## Timing
- Reset values: Y all ones, Slot=0, Scan_busy=0, Scan_done=0, a_q=0, FSM=IDLE. Reset mid-frame returns to these values immediately (asynchronously).
- Decode latency: one cycle from A/enable change to Y. Y changes only on clk edges, so there are no combinational glitches.
- Scan: Scan_start sampled high at edge t:
  - Y[0] low in cycles t+1..t+DWELL.
  - GAP in cycle t+DWELL+1.
  - Y[1] low starting at t+DWELL+2.
- Frame length without en pauses: WIDTH_OUT*(DWELL+1) cycles.
- Scan_busy is high in DRIVE and GAP, and is asserted the same cycle Y[0] first goes low.
- Scan_done coincides with the final GAP cycle; Scan_busy drops on the following cycle.
- Break-before-make: two Y bits are never low in the same cycle.

## Configuration
- TTL_DECODER_SEQ_CONTINUOUS_EN defined: after the final GAP, the FSM wraps to Slot=0/DRIVE instead of IDLE.
  - Scan_done still pulses once per frame.
  - Scan_busy stays high.
  - Scanning continues until Mode=0 or reset.
- Not defined: one frame per Scan_start, then IDLE.

## Test plan
All scenarios use WIDTH_OUT=8, DWELL=4 unless stated otherwise.
- Decode mode: en=1, LatchEn_bar=0, sweep A=0..7 -> one cycle later Y=8'hFE, 8'hFD … 8'h7F. Drop Enable3 -> Y=8'hFF the next cycle.
- Latch: A=3 with LatchEn_bar=0, then LatchEn_bar=1 and A=6 -> Y stays 8'hF7 until LatchEn_bar=0, then 8'hBF.
- Single frame: Mode=1, pulse Scan_start ->
  - Y[0] low for 4 cycles, 1 gap cycle, then Y[1] …
  - Scan_done high at cycle 40 after the start edge, Scan_busy low at cycle 41.
  - Y is never more than one bit low.
- En pause: Enable1_bar=1 for 3 cycles mid-DRIVE of slot 2 -> Y=8'hFF for those cycles; slot 2 completes 4 total low cycles; frame length becomes 43.
- Abort and reset: Mode=0 during slot 5 -> Y=8'hFF, Slot=0, no Scan_done. Restart the frame, then assert rst_n low mid-frame -> all outputs at reset values immediately.
- WIDTH_OUT=6 with the continuous macro:
  - A=7 in decode mode -> Y=6'h3F.
  - In scan mode, Scan_done every 30 cycles; Slot wraps 5->0 with Scan_busy continuously high.
